// File: rtl/sram_test_monitor.sv
// sram_test_monitor
//   Watches the write strobes of NUM_PORTS external SRAM ports and turns CPU
//   writes to magic addresses on MAGIC_PORT into a registered test verdict.
//   A write event is the first cycle of an access (CE_n and WE_n both low);
//   a long WE_n pulse produces a single event.
//
// Ports
//   clk_50M      system clock, rising edge
//   reset_btn    synchronous active-high reset
//   ram_addr     packed word addresses, port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
//   ram_ce_n     chip enables, active low, one per port
//   ram_we_n     write enables, active low, one per port
//   ram_be_n     byte enables, active low, 4 per port
//   ram_data     data buses, 32 per port
//   done         high once status leaves RUN
//   status       0 RUN, 1 PASS, 2 FAIL, 3 HALT, 4 TIMEOUT
//   out_valid    one-cycle pulse per full-word write to OUT_ADDR
//   out_data     data of the last full-word OUT_ADDR write
//   write_count  saturating count of write events on all ports
//   partial_err  sticky flag for sub-word writes to OUT_ADDR / HALT_ADDR
module sram_test_monitor #(
  parameter int unsigned           NUM_PORTS      = 2,
  parameter int unsigned           ADDR_WIDTH     = 20,
  parameter int unsigned           MAGIC_PORT     = 0,
  parameter logic [ADDR_WIDTH-1:0] OUT_ADDR       = 20'hC0000,
  parameter logic [ADDR_WIDTH-1:0] HALT_ADDR      = 20'h40000,
  parameter logic [31:0]           PASS_CODE      = 32'hAAAAAAAA,
  parameter logic [31:0]           FAIL_CODE      = 32'hDEAD0000,
  parameter logic [31:0]           FAIL_MASK      = 32'hFFFF0000,
  parameter logic [31:0]           TIMEOUT_CYCLES = 32'd0
) (
  input  logic                            clk_50M,
  input  logic                            reset_btn,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] ram_addr,
  input  logic [NUM_PORTS-1:0]            ram_ce_n,
  input  logic [NUM_PORTS-1:0]            ram_we_n,
  input  logic [NUM_PORTS*4-1:0]          ram_be_n,
  input  logic [NUM_PORTS*32-1:0]         ram_data,
  output logic                            done,
  output logic [2:0]                      status,
  output logic                            out_valid,
  output logic [31:0]                     out_data,
  output logic [31:0]                     write_count,
  output logic                            partial_err
);

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_PASS    = 3'd1,
    ST_FAIL    = 3'd2,
    ST_HALT    = 3'd3,
    ST_TIMEOUT = 3'd4
  } state_t;

  state_t                  state;
  logic [NUM_PORTS-1:0]    active;
  logic [NUM_PORTS-1:0]    prev_active;
  logic [NUM_PORTS-1:0]    evt;
  logic [31:0]             evt_cnt;
  logic [32:0]             wc_sum;
  logic [31:0]             cycle_cnt;

  logic                    m_evt;
  logic [ADDR_WIDTH-1:0]   m_addr;
  logic [31:0]             m_data;
  logic [3:0]              m_be_n;
  logic                    m_full;
  logic                    hit_out;
  logic                    hit_halt;
  logic                    is_pass;
  logic                    is_fail;
  logic                    timeout_hit;

  // Only the magic port's address/data/byte-enable buses feed logic; the rest
  // are watched for strobes alone. Fold everything here so the buses count as used.
  logic                    unused_bus_bits;
  assign unused_bus_bits = ^{ram_addr, ram_data, ram_be_n};

  always_comb begin
    active  = ~ram_ce_n & ~ram_we_n;
    evt     = active & ~prev_active;
    evt_cnt = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      evt_cnt = evt_cnt + {31'd0, evt[p]};
    end
  end

  assign wc_sum = {1'b0, write_count} + {1'b0, evt_cnt};

  assign m_evt    = evt[MAGIC_PORT];
  assign m_addr   = ram_addr[MAGIC_PORT*ADDR_WIDTH +: ADDR_WIDTH];
  assign m_data   = ram_data[MAGIC_PORT*32 +: 32];
  assign m_be_n   = ram_be_n[MAGIC_PORT*4 +: 4];
  assign m_full   = (m_be_n == 4'b0000);
  assign hit_out  = m_evt && (m_addr == OUT_ADDR);
  assign hit_halt = m_evt && (m_addr == HALT_ADDR);
  assign is_pass  = (m_data == PASS_CODE);
  assign is_fail  = ((m_data & FAIL_MASK) == (FAIL_CODE & FAIL_MASK));
  assign timeout_hit = (TIMEOUT_CYCLES != 32'd0) && (cycle_cnt == TIMEOUT_CYCLES - 32'd1);

  assign status = state;
  assign done   = (state != ST_RUN);

  always_ff @(posedge clk_50M) begin
    if (reset_btn) begin
      state       <= ST_RUN;
      prev_active <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      write_count <= '0;
      partial_err <= 1'b0;
      cycle_cnt   <= '0;
    end else begin
      prev_active <= active;
      out_valid   <= 1'b0;
      write_count <= wc_sum[32] ? '1 : wc_sum[31:0];

      if (state == ST_RUN) begin
        if ((hit_out || hit_halt) && !m_full) begin
          partial_err <= 1'b1;
        end
        if (hit_out && m_full) begin
          out_valid <= 1'b1;
          out_data  <= m_data;
        end

        // Verdict priority: magic write first, then timeout; the cycle
        // counter only advances while no transition is taken.
        if (hit_out && m_full && is_pass) begin
          state <= ST_PASS;
        end else if (hit_out && m_full && is_fail) begin
          state <= ST_FAIL;
        end else if (hit_halt && m_full && (m_data == 32'h1)) begin
          state <= ST_HALT;
        end else if (timeout_hit) begin
          state <= ST_TIMEOUT;
        end else begin
          cycle_cnt <= cycle_cnt + 32'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_test_monitor.sv
// Directed bench for sram_test_monitor: one instance with the timeout
// disabled and one with TIMEOUT_CYCLES=100, sharing all inputs.
module tb_sram_test_monitor;

  localparam logic [19:0] OUT_A  = 20'hC0000;
  localparam logic [19:0] HALT_A = 20'h40000;

  logic        clk_50M = 1'b0;
  logic        reset_btn;
  logic [39:0] ram_addr;
  logic [1:0]  ram_ce_n;
  logic [1:0]  ram_we_n;
  logic [7:0]  ram_be_n;
  logic [63:0] ram_data;

  logic        done, out_valid, partial_err;
  logic [2:0]  status;
  logic [31:0] out_data, write_count;

  logic        to_done, to_out_valid, to_partial_err;
  logic [2:0]  to_status;
  logic [31:0] to_out_data, to_write_count;

  int n_assert = 0;
  int n_fail   = 0;

  always #10 clk_50M = ~clk_50M;

  sram_test_monitor u_dut (
    .clk_50M(clk_50M), .reset_btn(reset_btn), .ram_addr(ram_addr),
    .ram_ce_n(ram_ce_n), .ram_we_n(ram_we_n), .ram_be_n(ram_be_n),
    .ram_data(ram_data), .done(done), .status(status),
    .out_valid(out_valid), .out_data(out_data),
    .write_count(write_count), .partial_err(partial_err)
  );

  sram_test_monitor #(.TIMEOUT_CYCLES(32'd100)) u_to (
    .clk_50M(clk_50M), .reset_btn(reset_btn), .ram_addr(ram_addr),
    .ram_ce_n(ram_ce_n), .ram_we_n(ram_we_n), .ram_be_n(ram_be_n),
    .ram_data(ram_data), .done(to_done), .status(to_status),
    .out_valid(to_out_valid), .out_data(to_out_data),
    .write_count(to_write_count), .partial_err(to_partial_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_50M);
      #1;
    end
  endtask

  task automatic start_write(input int p, input logic [19:0] a, input logic [31:0] d,
                             input logic [3:0] be);
    ram_addr[p*20 +: 20] = a;
    ram_data[p*32 +: 32] = d;
    ram_be_n[p*4 +: 4]   = be;
    ram_ce_n[p]          = 1'b0;
    ram_we_n[p]          = 1'b0;
  endtask

  task automatic end_write(input int p);
    ram_ce_n[p]        = 1'b1;
    ram_we_n[p]        = 1'b1;
    ram_be_n[p*4 +: 4] = 4'hF;
  endtask

  task automatic do_reset();
    reset_btn = 1'b1;
    tick();
    reset_btn = 1'b0;
  endtask

  initial begin
    reset_btn = 1'b1;
    ram_addr  = '0;
    ram_data  = '0;
    ram_ce_n  = 2'b11;
    ram_we_n  = 2'b11;
    ram_be_n  = 8'hFF;
    tick(2);
    chk("rst_status", {29'd0, status}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_write_count", write_count, 32'd0);
    chk("rst_partial_err", {31'd0, partial_err}, 32'd0);
    reset_btn = 1'b0;

    // Non-verdict value to OUT_ADDR
    start_write(0, OUT_A, 32'h00000004, 4'b0000);
    tick();
    chk("t1_out_valid", {31'd0, out_valid}, 32'd1);
    chk("t1_out_data", out_data, 32'h00000004);
    chk("t1_status", {29'd0, status}, 32'd0);
    chk("t1_write_count", write_count, 32'd1);
    end_write(0);
    tick();
    chk("t1_out_valid_drop", {31'd0, out_valid}, 32'd0);

    // PASS with WE_n low for three cycles
    start_write(0, OUT_A, 32'hAAAAAAAA, 4'b0000);
    tick();
    chk("t2_status", {29'd0, status}, 32'd1);
    chk("t2_done", {31'd0, done}, 32'd1);
    chk("t2_write_count", write_count, 32'd2);
    tick(2);
    chk("t2_long_we_count", write_count, 32'd2);
    chk("t2_long_we_valid", {31'd0, out_valid}, 32'd0);
    end_write(0);
    tick();
    start_write(0, OUT_A, 32'hDEAD0000, 4'b0000);
    tick();
    chk("t2_hold_status", {29'd0, status}, 32'd1);
    chk("t2_hold_valid", {31'd0, out_valid}, 32'd0);
    chk("t2_hold_out_data", out_data, 32'hAAAAAAAA);
    chk("t2_hold_count", write_count, 32'd3);
    end_write(0);
    do_reset();
    chk("t3_rst_status", {29'd0, status}, 32'd0);
    chk("t3_rst_count", write_count, 32'd0);

    // FAIL under mask
    start_write(0, OUT_A, 32'hDEAD0042, 4'b0000);
    tick();
    chk("t3_fail_status", {29'd0, status}, 32'd2);
    chk("t3_fail_data", out_data, 32'hDEAD0042);
    end_write(0);
    do_reset();

    // HALT
    start_write(0, HALT_A, 32'h00000001, 4'b0000);
    tick();
    chk("t3_halt_status", {29'd0, status}, 32'd3);
    chk("t3_halt_valid", {31'd0, out_valid}, 32'd0);
    chk("t3_halt_count", write_count, 32'd1);
    end_write(0);
    do_reset();

    // Partial write to OUT_ADDR
    start_write(0, OUT_A, 32'hAAAAAAAA, 4'b1110);
    tick();
    chk("t4_partial_err", {31'd0, partial_err}, 32'd1);
    chk("t4_partial_status", {29'd0, status}, 32'd0);
    chk("t4_partial_valid", {31'd0, out_valid}, 32'd0);
    chk("t4_partial_count", write_count, 32'd1);
    end_write(0);
    tick();

    // OUT_ADDR on the non-magic port
    start_write(1, OUT_A, 32'hAAAAAAAA, 4'b0000);
    tick();
    chk("t4_port1_status", {29'd0, status}, 32'd0);
    chk("t4_port1_valid", {31'd0, out_valid}, 32'd0);
    chk("t4_port1_count", write_count, 32'd2);
    end_write(1);
    tick();

    // Back-to-back with one idle cycle, then address change under held WE_n
    start_write(0, 20'h00010, 32'h5, 4'b0000);
    tick();
    end_write(0);
    tick();
    start_write(0, 20'h00010, 32'h5, 4'b0000);
    tick();
    chk("t5_b2b_count", write_count, 32'd4);
    ram_addr[19:0]  = OUT_A;
    ram_data[31:0]  = 32'hAAAAAAAA;
    tick();
    chk("t5_held_count", write_count, 32'd4);
    chk("t5_held_status", {29'd0, status}, 32'd0);
    end_write(0);
    tick();

    start_write(0, OUT_A, 32'h12345678, 4'b0000);
    tick();
    chk("t6_out_data", out_data, 32'h12345678);
    chk("t6_status", {29'd0, status}, 32'd0);
    end_write(0);
    tick();

    // Both ports in one cycle, then reset in the next
    start_write(0, 20'h00100, 32'h1, 4'b0000);
    start_write(1, 20'h00200, 32'h2, 4'b0000);
    tick();
    chk("t6_dual_count", write_count, 32'd7);
    end_write(0);
    end_write(1);
    reset_btn = 1'b1;
    tick();
    reset_btn = 1'b0;
    chk("t6_rst_status", {29'd0, status}, 32'd0);
    chk("t6_rst_done", {31'd0, done}, 32'd0);
    chk("t6_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("t6_rst_out_data", out_data, 32'd0);
    chk("t6_rst_count", write_count, 32'd0);
    chk("t6_rst_partial", {31'd0, partial_err}, 32'd0);

    // Timeout boundary (T=100)
    do_reset();
    tick(99);
    chk("to_cycle99_status", {29'd0, to_status}, 32'd0);
    tick();
    chk("to_cycle100_status", {29'd0, to_status}, 32'd4);
    chk("to_cycle100_done", {31'd0, to_done}, 32'd1);
    chk("to_disabled_status", {29'd0, status}, 32'd0);

    // PASS in cycle 99 beats the timeout
    do_reset();
    tick(99);
    start_write(0, OUT_A, 32'hAAAAAAAA, 4'b0000);
    tick();
    chk("to_pass_wins", {29'd0, to_status}, 32'd1);
    end_write(0);
    tick(3);
    chk("to_pass_holds", {29'd0, to_status}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
